// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback scheduler: widths,
// register-index type and writeback requester identifiers.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RIDX_W = 5;

  typedef logic [RIDX_W-1:0] reg_idx_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter between the ALU (A) and load (M) writeback
// requesters; last_grant remembers the most recent transfer.
module rf_rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_valid,
  input  logic m_valid,
  output logic a_grant,
  output logic m_grant
);

  req_id_e last_q, last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ_M;  // A wins the first conflict after reset
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      last_q <= last_d;
    end
  end

  // A grant always implies a transfer, since grants are only given to valid requesters.
  always_comb begin
    last_d = last_q;
    if (a_grant) begin
      last_d = REQ_A;
    end else if (m_grant) begin
      last_d = REQ_M;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    a_grant = 1'b0;
    m_grant = 1'b0;
    if (!reset) begin
      if (a_valid && m_valid) begin
        a_grant = (last_q == REQ_M);
        m_grant = (last_q == REQ_A);
      end else begin
        a_grant = a_valid;
        m_grant = m_valid;
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler: arbitrates A/M writebacks into one
// registered write port and tracks pending destinations in a busy scoreboard.
// Optional feature: RF_WB_BYPASS_EN adds write-stage bypass outputs.
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int NREG = rf_pkg::NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  input  reg_idx_t        a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            m_valid,
  input  reg_idx_t        m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic            m_ready,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rd,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic            busy1,
  output logic            busy2,
`ifdef RF_WB_BYPASS_EN
  output logic [XLEN-1:0] byp1,
  output logic [XLEN-1:0] byp2,
  output logic            hit1,
  output logic            hit2,
`endif
  output logic            wr_en,
  output reg_idx_t        wr_rd,
  output logic [XLEN-1:0] wr_data
);

  logic            xfer;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy_q, busy_d;
  logic            pend1, pend2;

  rf_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .m_valid (m_valid),
    .a_grant (a_ready),
    .m_grant (m_ready)
  );

  assign xfer     = a_ready | m_ready;
  assign sel_rd   = a_ready ? a_rd   : m_rd;
  assign sel_data = a_ready ? a_data : m_data;

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_rd   <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer && (sel_rd != '0);
      if (xfer) begin
        wr_rd   <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

  // Clear applied before set so an issue to the same index in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign pend1 = (rs1 != '0) && busy_q[rs1];
  assign pend2 = (rs2 != '0) && busy_q[rs2];

`ifdef RF_WB_BYPASS_EN
  assign hit1  = wr_en && (wr_rd == rs1) && (rs1 != '0);
  assign hit2  = wr_en && (wr_rd == rs2) && (rs2 != '0);
  assign byp1  = wr_data;
  assign byp2  = wr_data;
  assign busy1 = pend1 && !hit1;
  assign busy2 = pend2 && !hit2;
`else
  assign busy1 = pend1;
  assign busy2 = pend2;
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed testbench for rf_wb_sched: expected writes are queued at issue
// and a negedge monitor compares them against the register-file write port.
module tb_rf_wb_sched;
  import rf_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, m_valid, iss_valid;
  reg_idx_t     a_rd, m_rd, iss_rd, rs1, rs2;
  logic [W-1:0] a_data, m_data;
  logic         a_ready, m_ready, busy1, busy2, wr_en;
  reg_idx_t     wr_rd;
  logic [W-1:0] wr_data;
`ifdef RF_WB_BYPASS_EN
  logic [W-1:0] byp1, byp2;
  logic         hit1, hit2;
`endif

  typedef struct packed {
    reg_idx_t     rd;
    logic [W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .m_valid   (m_valid),
    .m_rd      (m_rd),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy1     (busy1),
    .busy2     (busy2),
`ifdef RF_WB_BYPASS_EN
    .byp1      (byp1),
    .byp2      (byp2),
    .hit1      (hit1),
    .hit2      (hit2),
`endif
    .wr_en     (wr_en),
    .wr_rd     (wr_rd),
    .wr_data   (wr_data)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input reg_idx_t rd, input logic [W-1:0] d);
    a_valid = v; a_rd = rd; a_data = d;
  endtask

  task automatic drive_m(input logic v, input reg_idx_t rd, input logic [W-1:0] d);
    m_valid = v; m_rd = rd; m_data = d;
  endtask

  task automatic push(input reg_idx_t rd, input logic [W-1:0] d);
    wr_t e;
    e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected write", {27'd0, wr_rd}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write rd", {27'd0, wr_rd}, {27'd0, e.rd});
        check("write data", wr_data, e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    iss_valid = 1'b0; iss_rd = '0; rs1 = 5'd5; rs2 = '0;
    drive_a(1'b1, 5'd1, 32'h1);
    drive_m(1'b1, 5'd2, 32'h2);
    #12;
    check("reset a_ready", {31'd0, a_ready}, 0);
    check("reset m_ready", {31'd0, m_ready}, 0);
    check("reset wr_en", {31'd0, wr_en}, 0);
    check("reset wr_rd", {27'd0, wr_rd}, 0);
    check("reset wr_data", wr_data, 0);
    check("reset busy1", {31'd0, busy1}, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b0, '0, '0);
    drive_m(1'b0, '0, '0);
    step();
    step();

    // Conflict after reset: A first, then M, then lone A, all back-to-back.
    drive_a(1'b1, 5'd3, 32'h33);
    drive_m(1'b1, 5'd4, 32'h44);
    #1;
    check("conflict1 a_ready", {31'd0, a_ready}, 1);
    check("conflict1 m_ready", {31'd0, m_ready}, 0);
    push(5'd3, 32'h33);
    step();
    check("b2b wr_en 1", {31'd0, wr_en}, 1);
    drive_a(1'b1, 5'd6, 32'h66);
    #1;
    check("conflict2 m_ready", {31'd0, m_ready}, 1);
    check("conflict2 a_ready", {31'd0, a_ready}, 0);
    push(5'd4, 32'h44);
    step();
    check("b2b wr_en 2", {31'd0, wr_en}, 1);
    drive_m(1'b0, '0, '0);
    #1;
    check("lone a_ready rd6", {31'd0, a_ready}, 1);
    push(5'd6, 32'h66);
    step();
    check("b2b wr_en 3", {31'd0, wr_en}, 1);

    // Lone A write rd5.
    drive_a(1'b1, 5'd5, 32'h11);
    #1;
    check("lone a_ready rd5", {31'd0, a_ready}, 1);
    check("lone m_ready rd5", {31'd0, m_ready}, 0);
    push(5'd5, 32'h11);
    step();
    drive_a(1'b0, '0, '0);

    // Scoreboard set by issue, cleared the edge after the write.
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    #1;
    check("busy7 before set", {31'd0, busy1}, 0);
    step();
    iss_valid = 1'b0;
    #1;
    check("busy7 set", {31'd0, busy1}, 1);
    step();
    check("busy7 held", {31'd0, busy1}, 1);
    drive_a(1'b1, 5'd7, 32'h77);
    #1;
    check("a_ready rd7", {31'd0, a_ready}, 1);
    push(5'd7, 32'h77);
    step();
    drive_a(1'b0, '0, '0);
`ifndef RF_WB_BYPASS_EN
    check("busy7 during write", {31'd0, busy1}, 1);
`else
    check("busy7 forced by hit", {31'd0, busy1}, 0);
    check("hit1 rd7", {31'd0, hit1}, 1);
    check("byp1 rd7", byp1, 32'h77);
`endif
    step();
    check("busy7 cleared", {31'd0, busy1}, 0);

    // Write to x0: accepted, no write, x0 never busy.
    drive_m(1'b1, 5'd0, 32'hFF);
    iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    #1;
    check("m_ready rd0", {31'd0, m_ready}, 1);
    step();
    drive_m(1'b0, '0, '0);
    iss_valid = 1'b0;
    check("rd0 wr_en", {31'd0, wr_en}, 0);
    #1;
    check("busy x0", {31'd0, busy1}, 0);

    // Set and clear of the same index in one cycle: set wins.
    iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
    step();
    iss_valid = 1'b0;
    check("busy9 set", {31'd0, busy2}, 1);
    drive_a(1'b1, 5'd9, 32'h99);
    #1;
    check("a_ready rd9", {31'd0, a_ready}, 1);
    push(5'd9, 32'h99);
    step();
    drive_a(1'b0, '0, '0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    check("busy9 set wins", {31'd0, busy2}, 1);
    step();
    check("busy9 stays", {31'd0, busy2}, 1);

    // last_grant was A (rd9) and idle cycles kept it: M wins the conflict.
    drive_a(1'b1, 5'd10, 32'h0A);
    drive_m(1'b1, 5'd11, 32'h0B);
    #1;
    check("conflict3 m_ready", {31'd0, m_ready}, 1);
    check("conflict3 a_ready", {31'd0, a_ready}, 0);
    push(5'd11, 32'h0B);
    step();
    drive_m(1'b0, '0, '0);
    #1;
    check("conflict4 a_ready", {31'd0, a_ready}, 1);
    push(5'd10, 32'h0A);
    step();
    drive_a(1'b0, '0, '0);

    // Asynchronous reset while a write is in the write stage.
    iss_valid = 1'b1; iss_rd = 5'd12; rs1 = 5'd12;
    step();
    iss_valid = 1'b0;
    drive_a(1'b1, 5'd15, 32'h55);
    drive_m(1'b1, 5'd14, 32'h14);
    #1;
    check("pre-reset m_ready", {31'd0, m_ready}, 1);
    push(5'd14, 32'h14);
    step();
    check("pre-reset wr_en", {31'd0, wr_en}, 1);
    reset = 1'b1;
    #1;
    check("async reset wr_en", {31'd0, wr_en}, 0);
    check("async reset busy12", {31'd0, busy1}, 0);
    check("async reset busy9", {31'd0, busy2}, 0);
    check("async reset a_ready", {31'd0, a_ready}, 0);
    check("async reset m_ready", {31'd0, m_ready}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b0, '0, '0);
    drive_m(1'b0, '0, '0);
    step();

    // last_grant back to M after reset: A wins.
    drive_a(1'b1, 5'd16, 32'h16);
    drive_m(1'b1, 5'd17, 32'h17);
    #1;
    check("post-reset a_ready", {31'd0, a_ready}, 1);
    check("post-reset m_ready", {31'd0, m_ready}, 0);
    push(5'd16, 32'h16);
    step();
    drive_a(1'b0, '0, '0);
    #1;
    check("post-reset m second", {31'd0, m_ready}, 1);
    push(5'd17, 32'h17);
    step();
    drive_m(1'b0, '0, '0);
    step();
    step();
    check("expected queue drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 Parameters: XLEN, 32, register data width; NREG, 32, architectural register count (rd index is 5 bits).
REQ-002 Reset is asynchronous and active-high; one clock.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 a_valid/a_rd/a_data  in  1/5/XLEN  requester A (ALU writeback).
REQ-006 a_ready  out  1  A accepted this cycle.
REQ-007 m_valid/m_rd/m_data  in  1/5/XLEN  requester M (load writeback).
REQ-008 m_ready  out  1  M accepted this cycle.
REQ-009 iss_valid/iss_rd  in  1/5  decode marks rd pending.
REQ-010 rs1/rs2  in  5/5  hazard query indices.
REQ-011 busy1/busy2  out  1/1  queried register pending.
REQ-012 wr_en/wr_rd/wr_data  out  1/5/XLEN  register-file write port (we/rd/indata).

Function
REQ-013 Transfer occurs when valid and ready are both high at a rising edge; ready is combinational from valid and arbitration state.
REQ-014 One requester granted per cycle; the other's ready stays 0 and it holds valid, rd and data stable.
REQ-015 Arbitration: round-robin; last_grant flag selects; on conflict the requester not granted last wins; a lone valid requester always wins.
REQ-016 last_grant updates only on a transfer; idle cycles leave it unchanged.
REQ-017 Write stage registered: transfer at edge N drives wr_en=1, wr_rd, wr_data for cycle N+1 (latency 1); no transfer leaves wr_en=0.
REQ-018 A transfer with rd=0 is accepted (ready=1) but yields wr_en=0 in the next cycle.
REQ-019 Scoreboard busy[NREG-1:0]: iss_valid with iss_rd!=0 sets busy[iss_rd] at the edge; iss_rd=0 ignored.
REQ-020 Cycle with wr_en=1 clears busy[wr_rd] at the next edge.
REQ-021 Simultaneous set and clear of the same index: set wins.
REQ-022 busy1=busy[rs1], busy2=busy[rs2], combinational; rs=0 always returns 0.
REQ-023 Back-to-back transfers sustain one write per cycle with no bubble.

Reset
REQ-024 Reset clears wr_en, wr_rd, wr_data, all busy bits to 0, sets last_grant=M (A wins first conflict).
REQ-025 During reset a_ready=m_ready=0; an in-flight write stage is discarded, not completed.

Configuration
REQ-026 Macro RF_WB_BYPASS_EN: when defined, add outputs byp1/byp2 (XLEN) and hit1/hit2 (1); hit=wr_en & wr_rd==rs & rs!=0, byp=wr_data, and busy for that query forced 0 on a hit.
REQ-027 Without RF_WB_BYPASS_EN those ports do not exist and busy follows REQ-022 only.

Structure
REQ-028 Shared package rf_pkg holds XLEN, NREG, register-index typedef and requester-id enum {REQ_A, REQ_M}.
REQ-029 Sub-module rf_rr_arb2 (two-way round-robin arbiter with last_grant state) is natural; scoreboard stays in the top level.

Verification
REQ-030 A valid rd=5 data=0x11 alone -> a_ready=1, next cycle wr_en=1 wr_rd=5 wr_data=0x11.
REQ-031 A and M valid two cycles after reset (rd 3/4) -> A granted first, M second; writes rd3 then rd4 on consecutive cycles.
REQ-032 iss rd=7, query rs1=7 -> busy1=1 until cycle after wr_en with wr_rd=7, then 0.
REQ-033 M rd=0 data=0xFF -> m_ready=1, next cycle wr_en=0; busy1 for rs1=0 stays 0.
REQ-034 iss rd=9 same cycle wr_en wr_rd=9 -> busy[9] stays 1.
REQ-035 Reset asserted mid-stream with wr_en=1 -> wr_en, busy, readies 0 immediately, without waiting for clk.
